// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
    logic                    misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous output FIFO with async reset and synchronous clear
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  // Reads as zero when empty so the decode-side outputs are clean after reset/flush.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with {pc, instr} output buffer
// Optional FETCH_MISALIGN_TRAP_EN: misaligned PCs bypass memory and push a trap entry.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            instr_misalign
`endif
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam int EW = 2*XLEN + 1;
`else
  localparam int EW = 2*XLEN;
`endif

  logic [1:0]      state;
  logic [XLEN-1:0] pc_q;
  logic            drop;
  logic            accept;
  logic            misaligned;
  logic            fifo_push;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  // A slot is reserved at acceptance, so the eventual push can never overflow.
  assign pc_ready       = rst_n && (state == S_IDLE) && !flush && (fifo_count < CW'(FIFO_DEPTH));
  assign accept         = pc_valid && pc_ready;
  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = imem_req_valid ? {pc_q[XLEN-1:2], 2'b00} : '0;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = (pc_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    fifo_push = 1'b0;
    push_data = '0;
    if (state == S_WAIT && imem_rsp_valid && !drop && !flush) begin
      fifo_push = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      push_data = {1'b0, pc_q, imem_rsp_data};
`else
      push_data = {pc_q, imem_rsp_data};
`endif
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    else if (accept && misaligned) begin
      fifo_push = 1'b1;
      push_data = {1'b1, pc_in, {XLEN{1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc_q  <= '0;
      drop  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && !misaligned) begin
            pc_q  <= pc_in;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          // A flushed request is still completed; only its response is dropped.
          if (flush)          drop  <= 1'b1;
          if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            drop  <= 1'b0;
            state <= S_IDLE;
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (instr_valid && instr_ready),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instr_valid = !fifo_empty;
  assign instr_data  = head[XLEN-1:0];
  assign instr_pc    = head[2*XLEN-1:XLEN];
`ifdef FETCH_MISALIGN_TRAP_EN
  assign instr_misalign = head[2*XLEN];
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly downstream of the program-counter register.
- Accepts the current PC through a valid/ready handshake and issues one request at a time to instruction memory.
- Captures the returned word and buffers {pc, instr} pairs in a small FIFO for the decode stage.
- pc_ready low stalls the PC register; flush discards all buffered and in-flight fetches on a redirect.

Parameters:
XLEN, 32, PC and instruction word width.
FIFO_DEPTH, 2, output buffer entries; power of two, at least 2.

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
pc_in  in  XLEN  PC to fetch (from pc register)
pc_valid  in  1  pc_in is valid
pc_ready  out  1  fetch unit accepts pc_in this cycle; low stalls the PC register
flush  in  1  redirect; discard buffered and in-flight fetches
imem_req_valid  out  1  memory request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response data valid
imem_rsp_data  in  XLEN  fetched instruction word
instr_valid  out  1  FIFO head valid to decode
instr_ready  in  1  decode consumes head
instr_data  out  XLEN  instruction at FIFO head
instr_pc  out  XLEN  PC of instruction at FIFO head

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM to IDLE; FIFO empty.
  - pc_ready, imem_req_valid, instr_valid = 0.
  - imem_addr, instr_data, instr_pc = 0.
  - drop flag cleared.
  - Reset mid-request abandons the request; a response arriving after reset release while in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: pc_ready = !flush && (fifo_count < FIFO_DEPTH). On pc_valid && pc_ready, register pc_in and go to REQ.
  - REQ: imem_req_valid = 1, imem_addr = {pc[XLEN-1:2], 2'b00}; both held stable until imem_req_ready. On acceptance go to WAIT.
  - WAIT: on imem_rsp_valid, push {pc, imem_rsp_data} into the FIFO (or discard it if drop is set), clear drop, go to IDLE.
- At most one outstanding request. A slot is reserved at acceptance: PC is accepted only if the FIFO is not full, so a push never overflows.
- Latency with a zero-wait memory (req_ready = 1, response one cycle after acceptance):
  - PC accepted at edge N.
  - imem_req_valid high in cycle N+1; response in N+2.
  - instr_valid high in N+3.
  - Throughput is one instruction per 3 cycles.
- FIFO behaviour:
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle is legal at any occupancy, including full; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - instr_valid = !empty. Head data is stable while instr_valid && !instr_ready.
- flush:
  - Empties the FIFO at the next edge; instr_valid = 0 the following cycle.
  - pc_ready = 0 during the flush cycle.
  - In REQ: the request stays valid until accepted (no withdrawal), drop is set, and the response is discarded.
  - In WAIT: drop is set; if imem_rsp_valid arrives in the same cycle as flush, that response is discarded.
  - In IDLE: the FIFO is cleared only.
- Simultaneous flush and pop: flush wins.
- Simultaneous flush and push: the entry is not written.

Optional Feature:
Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output instr_misalign (1 bit), stored per FIFO entry.
  - An accepted PC with pc[1:0] != 0 issues no memory request; the FSM goes IDLE -> IDLE.
  - It pushes an entry with instr_data = 0, instr_pc = pc, instr_misalign = 1.
- Undefined:
  - Low two PC bits are ignored for addressing (imem_addr forced aligned).
  - instr_pc keeps the full original PC.
  - No misalign output exists.

Decomposition:
- Package fetch_pkg:
  - XLEN default constant.
  - fetch_state_t enum {IDLE, REQ, WAIT}.
  - fetch_entry_t struct {pc, instr, misalign}.
- Sub-module fetch_fifo: parameterised synchronous FIFO.
  - Async active-low reset plus synchronous clear.
  - Push/pop, full/empty, count.
  - Instantiated once.

Test Plan:
- Reset then pc_in=0x0 with pc_valid, zero-wait memory returning 0x00500093 -> imem_addr=0x0 in cycle 1; instr_valid in cycle 3 with instr_pc=0x0, instr_data=0x00500093.
- Stream 0x0,0x4,0x8 with instr_ready=0 -> two entries buffered; pc_ready=0 with FIFO full. Raise instr_ready -> outputs in order 0x0, 0x4, then 0x8 fetched; no loss or duplication.
- imem_req_ready held low 4 cycles -> imem_req_valid and imem_addr stable for those cycles; pc_ready=0 throughout.
- flush asserted in WAIT with 1 entry buffered; response 0xDEADBEEF arrives next cycle -> FIFO empty, response discarded, instr_valid stays 0; the next PC 0x100 fetches normally.
- rst_n pulsed low while in WAIT -> all outputs 0 immediately; a stale imem_rsp_valid after release is ignored.
- FETCH_MISALIGN_TRAP_EN defined, pc_in=0x6 -> no imem_req_valid; entry with instr_pc=0x6, instr_misalign=1. Undefined: imem_addr=0x4 and instr_pc=0x6.
